uart_fifo_tx: RTL and testbench

//   Drain side of the 8-bit UART byte FIFO. Pops bytes from a show-ahead FIFO
//   and serializes each one as an 8N1 UART frame (LSB first) on tx.

---
 rtl/uart_fifo_tx.sv | 106 ++++++++++
 tb/tb_uart_fifo_tx.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: pops bytes from a show-ahead FIFO and sends them as UART frames (8N1, or 8E1 with UART_TX_PARITY_EN)
module uart_fifo_tx #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_rdata,
   output logic       fifo_pop,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);
   localparam int CPB = CLK_FREQ / BAUD;
   localparam int BW  = $clog2(CPB);
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   logic par;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
   state_t state, state_n;
   logic [BW-1:0] baud_cnt, baud_n;
   logic [2:0] bit_cnt, bit_n;
   logic [7:0] shift_reg, shift_n;
   logic tx_n, baud_end;
   assign baud_end = baud_cnt == BW'(CPB - 1);
   assign fifo_pop = state == IDLE && !fifo_empty && !rst;
   // next state, counters and shifter; the registered tx is derived from the next state
   always_comb begin
      state_n = state;
      baud_n  = baud_cnt + BW'(1);
      bit_n   = bit_cnt;
      shift_n = shift_reg;
      case (state)
         IDLE: begin
            baud_n = '0;
            if (!fifo_empty) begin
               state_n = START;
               shift_n = fifo_rdata;
            end
         end
         START: if (baud_end) begin
            state_n = DATA;
            baud_n  = '0;
            bit_n   = '0;
         end
         DATA: if (baud_end) begin
            baud_n  = '0;
            shift_n = shift_reg >> 1;
            bit_n   = bit_cnt + 3'd1;
`ifdef UART_TX_PARITY_EN
            if (bit_cnt == 3'd7) state_n = PARITY;
`else
            if (bit_cnt == 3'd7) state_n = STOP;
`endif
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (baud_end) begin
            state_n = STOP;
            baud_n  = '0;
         end
`endif
         STOP: if (baud_end) begin
            state_n = IDLE;
            baud_n  = '0;
         end
         default: begin
            state_n = IDLE;
            baud_n  = '0;
         end
      endcase
      tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
`ifdef UART_TX_PARITY_EN
      if (state_n == PARITY) tx_n = par;
`endif
   end
   // state and registered outputs; reset drops any partial frame
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         tx        <= 1'b1;
         tx_busy   <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         state     <= state_n;
         baud_cnt  <= baud_n;
         bit_cnt   <= bit_n;
         shift_reg <= shift_n;
         tx        <= tx_n;
         tx_busy   <= state_n != IDLE;
         tx_done   <= state_n == STOP && baud_n == BW'(CPB - 1);
      end
   end
`ifdef UART_TX_PARITY_EN
   // even parity of the byte, captured when it is popped
   always_ff @(posedge clk) begin
      if (rst) par <= 1'b0;
      else if (fifo_pop) par <= ^fifo_rdata;
   end
`endif
endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb_uart_fifo_tx: directed checks of uart_fifo_tx with CLKS_PER_BIT=10 (honours UART_TX_PARITY_EN)
module tb_uart_fifo_tx;
   localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FL = NB * CPB;
   logic clk = 1'b0, rst = 1'b1, fifo_empty = 1'b1;
   logic [7:0] fifo_rdata = 8'h00;
   logic fifo_pop, tx, tx_busy, tx_done;
   logic s_pop, s_tx, s_busy, s_done;
   logic tx_l [0:599];
   logic pop_l [0:599];
   logic busy_l [0:599];
   logic done_l [0:599];
   logic [7:0] q[$];
   int tests = 0, fails = 0;
   uart_fifo_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
      .fifo_pop(fifo_pop), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      fifo_empty = q.size() == 0;
      fifo_rdata = fifo_empty ? 8'h00 : q[0];
      #1;
      s_pop = fifo_pop; s_tx = tx; s_busy = tx_busy; s_done = tx_done;
      @(posedge clk);
      if (s_pop && q.size() > 0) void'(q.pop_front());
      #1;
   endtask
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         tx_l[i] = s_tx; pop_l[i] = s_pop; busy_l[i] = s_busy; done_l[i] = s_done;
      end
   endtask
   task automatic find_pops(input int n, output int p1, output int p2, output int cnt);
      p1 = -1; p2 = -1; cnt = 0;
      for (int i = 0; i < n; i++) if (pop_l[i] === 1'b1) begin
         if (cnt == 0) p1 = i;
         else if (cnt == 1) p2 = i;
         cnt++;
      end
   endtask
   function automatic logic exp_tx(input logic [7:0] b, input int k);
      if (k <= 0 || k > FL) return 1'b1;
      if (k <= 10) return 1'b0;
      if (k <= 90) return b[(k - 11) / 10];
      if (NB == 11 && k <= 100) return ^b;
      return 1'b1;
   endfunction
   task automatic check_frame(input string tag, input int p, input logic [7:0] b);
      logic [7:0] d;
      if (p < 0) return;
      for (int k = 0; k <= FL; k++) begin
         chk($sformatf("%s_tx@%0d", tag, k), tx_l[p + k], exp_tx(b, k));
         chk($sformatf("%s_busy@%0d", tag, k), busy_l[p + k], k >= 1 && k <= FL);
         chk($sformatf("%s_done@%0d", tag, k), done_l[p + k], k == FL);
      end
      for (int i = 0; i < 8; i++) d[i] = tx_l[p + 16 + 10 * i];
      chk({tag, "_decode"}, d, b);
   endtask
   initial begin
      int p1, p2, cnt, viol;
      q.push_back(8'h11);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_pop", s_pop, 0);
         chk("rst_tx", tx, 1);
         chk("rst_busy", tx_busy, 0);
         chk("rst_done", tx_done, 0);
      end
      q.delete();
      rst = 1'b0;
      q.push_back(8'hA5);
      run(130);
      find_pops(130, p1, p2, cnt);
      chk("a5_pops", cnt, 1);
      chk("a5_pop_cycle", p1, 0);
      check_frame("a5", p1, 8'hA5);
      q.push_back(8'h00);
      q.push_back(8'hFF);
      run(2 * FL + 40);
      find_pops(2 * FL + 40, p1, p2, cnt);
      chk("b2b_pops", cnt, 2);
      chk("b2b_gap", p2 - p1, FL + 1);
      if (p1 >= 0) chk("b2b_idle_tx", tx_l[p1 + FL + 1], 1);
      check_frame("b2b_00", p1, 8'h00);
      check_frame("b2b_ff", p2, 8'hFF);
      run(500);
      viol = 0;
      for (int i = 0; i < 500; i++) if (tx_l[i] !== 1'b1 || pop_l[i] !== 1'b0 || busy_l[i] !== 1'b0) viol++;
      chk("empty_idle", viol, 0);
      q.push_back(8'h3C);
      step();
      chk("mid_pop", s_pop, 1);
      repeat (44) step();
      chk("mid_busy_before", tx_busy, 1);
      rst = 1'b1;
      q.push_back(8'h5A);
      step();
      chk("mid_tx_after_rst", tx, 1);
      chk("mid_busy_after_rst", tx_busy, 0);
      chk("mid_done_after_rst", tx_done, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("mid_rst_pop", s_pop, 0);
         chk("mid_rst_done", s_done, 0);
      end
      chk("mid_q_kept", q.size(), 1);
      rst = 1'b0;
      run(130);
      find_pops(130, p1, p2, cnt);
      chk("post_rst_pops", cnt, 1);
      chk("post_rst_pop_cycle", p1, 0);
      check_frame("post_rst_5a", p1, 8'h5A);
`ifdef UART_TX_PARITY_EN
      q.push_back(8'h07);
      run(130);
      find_pops(130, p1, p2, cnt);
      check_frame("par07", p1, 8'h07);
      if (p1 >= 0) chk("par07_bit", tx_l[p1 + 95], 1);
      q.push_back(8'h03);
      run(130);
      find_pops(130, p1, p2, cnt);
      check_frame("par03", p1, 8'h03);
      if (p1 >= 0) chk("par03_bit", tx_l[p1 + 95], 0);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
